bpsk_tx_sched: RTL and testbench

BPSK_TX_SCHED -- requirements
Module: bpsk_tx_sched

---
 rtl/bpsk_tx_sched.sv | 160 ++++++++++++++++
 tb/tb_bpsk_tx_sched.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bpsk_tx_sched.sv
// bpsk_tx_sched: two-requester frame scheduler in front of a BPSK modulator.
// Each accepted byte goes out as one frame: a fixed preamble, then the 8 data
// bits MSB first, then a silent gap of one bit period. When both requesters
// are waiting, arbitration alternates between them. A frame that is cut short
// by reset is dropped, not resumed.
module bpsk_tx_sched #(
    parameter int                 N        = 8,
    parameter int                 PRE_LEN  = 7,
    parameter logic [PRE_LEN-1:0] PREAMBLE = 7'b0110101
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce,
    input  logic       req0_valid,
    input  logic       req1_valid,
    input  logic [7:0] req0_data,
    input  logic [7:0] req1_data,
    output logic       req0_ready,
    output logic       req1_ready,
    output logic       mod_ce,
    output logic       mod_bit,
    output logic       busy,
    output logic       grant,
    output logic       frame_done
);

    // The bit index has to reach both the last preamble bit and data bit 7.
    localparam int CW      = (N > 1) ? $clog2(N) : 1;
    localparam int BIT_MAX = (PRE_LEN > 8) ? PRE_LEN : 8;
    localparam int BW      = $clog2(BIT_MAX);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        DATA = 2'd2,
        GAP  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [BW-1:0]   bit_q, bit_d;
    logic [7:0]      shreg_q, shreg_d;
    logic            grant_q, grant_d;
    logic            last_grant_q, last_grant_d;

    logic            bit_end;
    logic            winner;
    logic [(1<<BW)-1:0] pre_rev;

    // Preamble reversed so that it can be indexed directly by the bit index.
    always_comb begin
        pre_rev = '0;
        for (int i = 0; i < PRE_LEN; i++) begin
            pre_rev[i] = PREAMBLE[PRE_LEN-1-i];
        end
    end

    // State, counters and data registers; everything holds while ce is low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            bit_q        <= '0;
            shreg_q      <= '0;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
        end else if (ce) begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            shreg_q      <= shreg_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Next state, arbitration, handshake and end-of-frame pulse.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_d        = bit_q;
        shreg_d      = shreg_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        frame_done   = 1'b0;

        bit_end = (cnt_q == CW'(N - 1));
        // With both requesters waiting, the one not served last time wins.
        winner  = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;

        if (ce && !reset) begin
            unique case (state_q)
                IDLE: begin
                    if (req0_valid || req1_valid) begin
                        req0_ready   = ~winner;
                        req1_ready   = winner;
                        shreg_d      = winner ? req1_data : req0_data;
                        grant_d      = winner;
                        last_grant_d = winner;
                        cnt_d        = '0;
                        bit_d        = '0;
                        state_d      = PRE;
                    end
                end
                PRE: begin
                    if (bit_end) begin
                        cnt_d = '0;
                        if (bit_q == BW'(PRE_LEN - 1)) begin
                            bit_d   = '0;
                            state_d = DATA;
                        end else begin
                            bit_d = bit_q + BW'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        cnt_d   = '0;
                        shreg_d = {shreg_q[6:0], 1'b0};
                        if (bit_q == BW'(7)) begin
                            bit_d   = '0;
                            state_d = GAP;
                        end else begin
                            bit_d = bit_q + BW'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                GAP: begin
                    if (bit_end) begin
                        cnt_d      = '0;
                        state_d    = IDLE;
                        frame_done = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Modulator-facing outputs decoded from the registered state.
    always_comb begin
        mod_ce = ce && ((state_q == PRE) || (state_q == DATA));
        busy   = (state_q != IDLE);
        grant  = grant_q;
        unique case (state_q)
            PRE:     mod_bit = pre_rev[bit_q];
            DATA:    mod_bit = shreg_q[7];
            default: mod_bit = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_bpsk_tx_sched.sv
// Directed bench for bpsk_tx_sched: a table-described first frame, alternating
// arbitration, ce gating, mid-frame reset and a second instance with N=4.
module tb_bpsk_tx_sched;

    localparam logic [6:0] PRE_PAT = 7'b0110101;

    logic clk = 1'b0;
    logic reset;
    logic ce, v0, v1, r0, r1, mce, mbit, busy, grant, fd;
    logic [7:0] d0, d1;

    logic ce_b, v0_b, v1_b, r0_b, r1_b, mce_b, mbit_b, busy_b, grant_b, fd_b;
    logic [7:0] d0_b, d1_b;

    int cmp_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    bpsk_tx_sched #(.N(8)) dut (
        .clk(clk), .reset(reset), .ce(ce),
        .req0_valid(v0), .req1_valid(v1),
        .req0_data(d0), .req1_data(d1),
        .req0_ready(r0), .req1_ready(r1),
        .mod_ce(mce), .mod_bit(mbit), .busy(busy),
        .grant(grant), .frame_done(fd)
    );

    bpsk_tx_sched #(.N(4)) dut_b (
        .clk(clk), .reset(reset), .ce(ce_b),
        .req0_valid(v0_b), .req1_valid(v1_b),
        .req0_data(d0_b), .req1_data(d1_b),
        .req0_ready(r0_b), .req1_ready(r1_b),
        .mod_ce(mce_b), .mod_bit(mbit_b), .busy(busy_b),
        .grant(grant_b), .frame_done(fd_b)
    );

    typedef struct {
        int   cycles;
        logic mce;
        logic mbit;
        logic busy;
        logic fd_last;
    } seg_t;

    typedef struct {
        logic ce;
        logic v0;
        logic v1;
        logic r0;
        logic r1;
    } idle_vec_t;

    seg_t      seg_tab[16];
    idle_vec_t idle_tab[3];

    task automatic chk(input string name, input logic act, input logic exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %b, want %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        cmp_cnt++;
        if (act != exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // Expected modulator bit at the k-th ce-high cycle of a frame.
    function automatic logic exp_bit(input int k, input logic [7:0] d, input int n);
        int idx;
        idx = k / n;
        if (idx < 7)       return PRE_PAT[6 - idx];
        else if (idx < 15) return d[7 - (idx - 7)];
        else               return 1'b0;
    endfunction

    // Follows one frame of the N=8 instance from the cycle after acceptance.
    task automatic check_frame(input logic [7:0] d, input logic g,
                               input bit toggle, input int ncyc);
        for (int k = 0; k < ncyc; k++) begin
            if (toggle) begin
                ce = 1'b0;
                #1;
                chk($sformatf("hold_mce k=%0d", k), mce, 1'b0);
                chk($sformatf("hold_mbit k=%0d", k), mbit, exp_bit(k, d, 8));
                chk($sformatf("hold_r0 k=%0d", k), r0, 1'b0);
                chk($sformatf("hold_fd k=%0d", k), fd, 1'b0);
                cyc();
                ce = 1'b1;
            end
            #1;
            chk($sformatf("mce k=%0d", k), mce, k < 120);
            chk($sformatf("mbit k=%0d", k), mbit, exp_bit(k, d, 8));
            chk($sformatf("busy k=%0d", k), busy, 1'b1);
            chk($sformatf("grant k=%0d", k), grant, g);
            chk($sformatf("fd k=%0d", k), fd, k == 127);
            chk($sformatf("r0 k=%0d", k), r0, 1'b0);
            chk($sformatf("r1 k=%0d", k), r1, 1'b0);
            cyc();
        end
    endtask

    initial begin
        int mce_hi;

        // Frame of 8'hA5 from requester 0: preamble 0110101, data 10100101, gap.
        seg_tab[0]  = '{8, 1'b1, 1'b0, 1'b1, 1'b0};
        seg_tab[1]  = '{8, 1'b1, 1'b1, 1'b1, 1'b0};
        seg_tab[2]  = '{8, 1'b1, 1'b1, 1'b1, 1'b0};
        seg_tab[3]  = '{8, 1'b1, 1'b0, 1'b1, 1'b0};
        seg_tab[4]  = '{8, 1'b1, 1'b1, 1'b1, 1'b0};
        seg_tab[5]  = '{8, 1'b1, 1'b0, 1'b1, 1'b0};
        seg_tab[6]  = '{8, 1'b1, 1'b1, 1'b1, 1'b0};
        seg_tab[7]  = '{8, 1'b1, 1'b1, 1'b1, 1'b0};
        seg_tab[8]  = '{8, 1'b1, 1'b0, 1'b1, 1'b0};
        seg_tab[9]  = '{8, 1'b1, 1'b1, 1'b1, 1'b0};
        seg_tab[10] = '{8, 1'b1, 1'b0, 1'b1, 1'b0};
        seg_tab[11] = '{8, 1'b1, 1'b0, 1'b1, 1'b0};
        seg_tab[12] = '{8, 1'b1, 1'b1, 1'b1, 1'b0};
        seg_tab[13] = '{8, 1'b1, 1'b0, 1'b1, 1'b0};
        seg_tab[14] = '{8, 1'b1, 1'b1, 1'b1, 1'b0};
        seg_tab[15] = '{8, 1'b0, 1'b0, 1'b1, 1'b1};

        // IDLE with ce low: no request may be accepted.
        idle_tab[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        idle_tab[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        idle_tab[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

        reset = 1'b1; ce = 1'b1;
        v0 = 1'b1; v1 = 1'b0; d0 = 8'hA5; d1 = 8'h00;
        ce_b = 1'b1; v0_b = 1'b0; v1_b = 1'b0; d0_b = 8'h00; d1_b = 8'h00;

        // Reset state.
        cyc();
        cyc();
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_grant", grant, 1'b0);
        chk("rst_mbit", mbit, 1'b0);
        chk("rst_mce", mce, 1'b0);
        chk("rst_fd", fd, 1'b0);
        chk("rst_r0", r0, 1'b0);
        chk("rst_r1", r1, 1'b0);
        chk("rst_busy_b", busy_b, 1'b0);

        // First cycle out of reset: requester 0 accepted immediately.
        reset = 1'b0;
        #1;
        chk("f1_r0", r0, 1'b1);
        chk("f1_r1", r1, 1'b0);
        chk("f1_busy_idle", busy, 1'b0);
        cyc();
        v0 = 1'b0;

        // Frame 1 from the table; requester 1 raises valid during the preamble.
        mce_hi = 0;
        for (int s = 0; s < 16; s++) begin
            if (s == 2) begin
                v1 = 1'b1;
                d1 = 8'hC3;
            end
            for (int c = 0; c < seg_tab[s].cycles; c++) begin
                #1;
                if (mce) mce_hi++;
                chk($sformatf("t_mce s=%0d c=%0d", s, c), mce, seg_tab[s].mce);
                chk($sformatf("t_mbit s=%0d c=%0d", s, c), mbit, seg_tab[s].mbit);
                chk($sformatf("t_busy s=%0d c=%0d", s, c), busy, seg_tab[s].busy);
                chk($sformatf("t_fd s=%0d c=%0d", s, c), fd,
                    seg_tab[s].fd_last && (c == seg_tab[s].cycles - 1));
                chk($sformatf("t_r1 s=%0d c=%0d", s, c), r1, 1'b0);
                chk($sformatf("t_grant s=%0d c=%0d", s, c), grant, 1'b0);
                cyc();
            end
        end
        chk_int("f1_mce_count", mce_hi, 120);

        // First IDLE cycle after frame_done: requester 1 accepted.
        #1;
        chk("f2_busy_idle", busy, 1'b0);
        chk("f2_r1", r1, 1'b1);
        chk("f2_r0", r0, 1'b0);
        cyc();
        d1 = 8'h35;
        v0 = 1'b1; d0 = 8'h3C;
        check_frame(8'hC3, 1'b1, 1'b0, 128);

        // Both waiting: requester 0 goes next.
        #1;
        chk("f3_r0", r0, 1'b1);
        chk("f3_r1", r1, 1'b0);
        cyc();
        d0 = 8'h5A;
        check_frame(8'h3C, 1'b0, 1'b1, 128);

        // IDLE with ce low holds off all requests.
        for (int i = 0; i < 3; i++) begin
            ce = idle_tab[i].ce;
            v0 = idle_tab[i].v0;
            v1 = idle_tab[i].v1;
            #1;
            chk($sformatf("idle_r0 i=%0d", i), r0, idle_tab[i].r0);
            chk($sformatf("idle_r1 i=%0d", i), r1, idle_tab[i].r1);
            chk($sformatf("idle_mce i=%0d", i), mce, 1'b0);
            chk($sformatf("idle_busy i=%0d", i), busy, 1'b0);
            cyc();
        end

        // Both waiting again: requester 1 goes next.
        ce = 1'b1; v0 = 1'b1; v1 = 1'b1;
        #1;
        chk("f4_r1", r1, 1'b1);
        chk("f4_r0", r0, 1'b0);
        cyc();
        v1 = 1'b0;

        // Run into DATA bit 3, then reset asynchronously mid-cycle.
        check_frame(8'h35, 1'b1, 1'b0, 82);
        #1;
        chk("pre_rst_mbit", mbit, 1'b1);
        #1;
        reset = 1'b1;
        #1;
        chk("arst_busy", busy, 1'b0);
        chk("arst_mbit", mbit, 1'b0);
        chk("arst_mce", mce, 1'b0);
        chk("arst_grant", grant, 1'b0);
        chk("arst_r0", r0, 1'b0);
        chk("arst_fd", fd, 1'b0);
        cyc();
        cyc();
        chk("arst_hold_busy", busy, 1'b0);
        reset = 1'b0;
        #1;
        chk("f5_r0", r0, 1'b1);
        chk("f5_r1", r1, 1'b0);
        cyc();
        v0 = 1'b0;
        check_frame(8'h5A, 1'b0, 1'b0, 128);
        #1;
        chk("f5_end_busy", busy, 1'b0);
        chk("f5_end_r0", r0, 1'b0);

        // Second instance, N=4, data 8'h00.
        v0_b = 1'b1;
        d0_b = 8'h00;
        #1;
        chk("b_r0", r0_b, 1'b1);
        cyc();
        v0_b = 1'b0;
        for (int k = 0; k < 64; k++) begin
            #1;
            chk($sformatf("b_mce k=%0d", k), mce_b, k < 60);
            chk($sformatf("b_mbit k=%0d", k), mbit_b, exp_bit(k, 8'h00, 4));
            chk($sformatf("b_busy k=%0d", k), busy_b, 1'b1);
            chk($sformatf("b_fd k=%0d", k), fd_b, k == 63);
            cyc();
        end
        #1;
        chk("b_end_busy", busy_b, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
